// File: rtl/rtc_pkg.sv
// Shared definitions for the menu FSM <-> RTC bus controller pair: FSM states,
// bus phase lengths, init sequence values and RTC register map.
package rtc_pkg;

    typedef enum logic [3:0] {
        ST_INIT = 4'd0,
        ST_IDLE = 4'd1,
        ST_ASU  = 4'd2,
        ST_APW  = 4'd3,
        ST_AH   = 4'd4,
        ST_DSU  = 4'd5,
        ST_DPW  = 4'd6,
        ST_DH   = 4'd7,
        ST_DONE = 4'd8
    } rtc_state_e;

    localparam int T_SU_DEF  = 2;
    localparam int T_PW_DEF  = 4;
    localparam int T_H_DEF   = 2;
    localparam int T_REC_DEF = 1;

    localparam logic [7:0] INIT_ADR = 8'h02;
    localparam logic [7:0] INIT_D0  = 8'h10;
    localparam logic [7:0] INIT_D1  = 8'h00;

    // RTC register map shared with the menu FSM
    localparam logic [7:0] RTC_SEG      = 8'h21;
    localparam logic [7:0] RTC_MIN      = 8'h22;
    localparam logic [7:0] RTC_HORA     = 8'h23;
    localparam logic [7:0] RTC_DIA      = 8'h24;
    localparam logic [7:0] RTC_MES      = 8'h25;
    localparam logic [7:0] RTC_ANIO     = 8'h26;
    localparam logic [7:0] RTC_DSEM     = 8'h27;
    localparam logic [7:0] RTC_TMR_SEG  = 8'h41;
    localparam logic [7:0] RTC_TMR_MIN  = 8'h42;
    localparam logic [7:0] RTC_TMR_HORA = 8'h43;
    localparam logic [7:0] RTC_TMR_CTRL = 8'h44;
    localparam logic [7:0] RTC_CMD_F0   = 8'hF0;
    localparam logic [7:0] RTC_CMD_F1   = 8'hF1;

    function automatic logic [4:0] phase_load(input int t);
        return 5'(t - 1);
    endfunction

endpackage

// File: rtl/rtc_bus_ctrl_chk.sv
// Protocol checker for the RTC bus controller outputs; simulation only,
// contributes no logic.
module rtc_bus_ctrl_chk (
    input logic CLK,
    input logic RST,
    input logic FRW,
    input logic Busy,
    input logic CS_n,
    input logic RD_n,
    input logic WR_n,
    input logic AD_oe
);

    a_no_strobe_overlap: assert property (@(posedge CLK) disable iff (RST) !(!RD_n && !WR_n));
    a_frw_one_cycle:     assert property (@(posedge CLK) disable iff (RST) FRW |=> !FRW);
    a_idle_cs_high:      assert property (@(posedge CLK) disable iff (RST) !Busy |-> CS_n);
    a_no_drive_on_read:  assert property (@(posedge CLK) disable iff (RST) !(AD_oe && !RD_n));

endmodule

// File: rtl/rtc_bus_ctrl.sv
// Responder side of the menu <-> RTC handshake: runs one multiplexed
// address/data bus cycle per accepted request, after a two-write init sequence.
module rtc_bus_ctrl
    import rtc_pkg::*;
#(
    parameter int T_SU  = T_SU_DEF,
    parameter int T_PW  = T_PW_DEF,
    parameter int T_H   = T_H_DEF,
    parameter int T_REC = T_REC_DEF
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Acceso,
    input  logic       Mod,
    input  logic [7:0] Dir,
    input  logic [7:0] Dato_W,
    output logic [7:0] Dato_R,
    output logic       FRW,
    output logic       Busy,
    output logic       CS_n,
    output logic       RD_n,
    output logic       WR_n,
    output logic       A_D,
    output logic [7:0] AD_out,
    output logic       AD_oe,
    input  logic [7:0] AD_in
);

    rtc_state_e state_r, state_s;
    logic [4:0] timer_r, timer_s, tdec_s;
    logic       tzero_s;
    logic [7:0] adr_r, adr_s, data_r, data_s, rdata_r, rdata_s;
    logic       wr_r, wr_s, init_idx_r, idx_s, init_fin_r, fin_s;
    logic       cs_n_r, cs_n_s, rd_n_r, rd_n_s, wr_n_r, wr_n_s;
    logic       a_d_r, a_d_s, ad_oe_r, ad_oe_s, frw_r, frw_s, busy_r, busy_s;
    logic [7:0] ad_out_r, ad_out_s;

    // Next-state, phase timer, transaction latching and read capture
    always_comb begin
        state_s = state_r;
        timer_s = timer_r;
        adr_s   = adr_r;
        data_s  = data_r;
        wr_s    = wr_r;
        idx_s   = init_idx_r;
        fin_s   = init_fin_r;
        rdata_s = rdata_r;
        tzero_s = (timer_r == 5'd0);
        tdec_s  = timer_r - 5'd1;
        case (state_r)
            ST_INIT: begin
                adr_s   = INIT_ADR;
                wr_s    = 1'b1;
                data_s  = init_idx_r ? INIT_D1 : INIT_D0;
                state_s = ST_ASU;
                timer_s = phase_load(T_SU);
            end
            ST_IDLE: begin
                if (!tzero_s) begin
                    timer_s = tdec_s;
                end else if (Acceso) begin
                    adr_s   = Dir;
                    wr_s    = Mod;
                    data_s  = Dato_W;
                    state_s = ST_ASU;
                    timer_s = phase_load(T_SU);
                end else begin
                    timer_s = 5'd0;
                end
            end
            ST_ASU: begin
                if (tzero_s) begin
                    state_s = ST_APW;
                    timer_s = phase_load(T_PW);
                end else begin
                    timer_s = tdec_s;
                end
            end
            ST_APW: begin
                if (tzero_s) begin
                    state_s = ST_AH;
                    timer_s = phase_load(T_H);
                end else begin
                    timer_s = tdec_s;
                end
            end
            ST_AH: begin
                if (tzero_s) begin
                    state_s = ST_DSU;
                    timer_s = phase_load(T_SU);
                end else begin
                    timer_s = tdec_s;
                end
            end
            ST_DSU: begin
                if (tzero_s) begin
                    state_s = ST_DPW;
                    timer_s = phase_load(T_PW);
                end else begin
                    timer_s = tdec_s;
                end
            end
            ST_DPW: begin
                if (tzero_s) begin
                    // Sample at the very end of the strobe, where the RTC output is settled
                    if (!wr_r) begin
                        rdata_s = AD_in;
                    end else begin
                        rdata_s = rdata_r;
                    end
                    state_s = ST_DH;
                    timer_s = phase_load(T_H);
                end else begin
                    timer_s = tdec_s;
                end
            end
            ST_DH: begin
                if (tzero_s) begin
                    state_s = ST_DONE;
                    timer_s = 5'd0;
                end else begin
                    timer_s = tdec_s;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
                timer_s = phase_load(T_REC);
                if (!init_fin_r && !init_idx_r) begin
                    idx_s   = 1'b1;
                    state_s = ST_INIT;
                    timer_s = 5'd0;
                end else begin
                    fin_s = 1'b1;
                end
            end
            default: begin
                state_s = ST_INIT;
                timer_s = 5'd0;
            end
        endcase
    end

    // Bus pin decode from the upcoming state so the pins register in step with it
    always_comb begin
        cs_n_s   = 1'b1;
        rd_n_s   = 1'b1;
        wr_n_s   = 1'b1;
        a_d_s    = 1'b0;
        ad_oe_s  = 1'b0;
        ad_out_s = 8'h00;
        frw_s    = 1'b0;
        busy_s   = 1'b1;
        case (state_s)
            ST_IDLE: busy_s = (timer_s != 5'd0);
            ST_ASU, ST_AH: begin
                cs_n_s   = 1'b0;
                ad_oe_s  = 1'b1;
                ad_out_s = adr_s;
            end
            ST_APW: begin
                cs_n_s   = 1'b0;
                wr_n_s   = 1'b0;
                ad_oe_s  = 1'b1;
                ad_out_s = adr_s;
            end
            ST_DSU, ST_DH: begin
                cs_n_s   = 1'b0;
                a_d_s    = 1'b1;
                ad_oe_s  = wr_s;
                ad_out_s = wr_s ? data_s : 8'h00;
            end
            ST_DPW: begin
                cs_n_s   = 1'b0;
                a_d_s    = 1'b1;
                wr_n_s   = ~wr_s;
                rd_n_s   = wr_s;
                ad_oe_s  = wr_s;
                ad_out_s = wr_s ? data_s : 8'h00;
            end
            ST_DONE: frw_s = 1'b1;
            default: busy_s = 1'b1;
        endcase
    end

    // State, timer, transaction and registered-output storage
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r    <= ST_INIT;
            timer_r    <= 5'd0;
            adr_r      <= 8'h00;
            data_r     <= 8'h00;
            wr_r       <= 1'b0;
            init_idx_r <= 1'b0;
            init_fin_r <= 1'b0;
            rdata_r    <= 8'h00;
            cs_n_r     <= 1'b1;
            rd_n_r     <= 1'b1;
            wr_n_r     <= 1'b1;
            a_d_r      <= 1'b0;
            ad_oe_r    <= 1'b0;
            ad_out_r   <= 8'h00;
            frw_r      <= 1'b0;
            busy_r     <= 1'b1;
        end else begin
            state_r    <= state_s;
            timer_r    <= timer_s;
            adr_r      <= adr_s;
            data_r     <= data_s;
            wr_r       <= wr_s;
            init_idx_r <= idx_s;
            init_fin_r <= fin_s;
            rdata_r    <= rdata_s;
            cs_n_r     <= cs_n_s;
            rd_n_r     <= rd_n_s;
            wr_n_r     <= wr_n_s;
            a_d_r      <= a_d_s;
            ad_oe_r    <= ad_oe_s;
            ad_out_r   <= ad_out_s;
            frw_r      <= frw_s;
            busy_r     <= busy_s;
        end
    end

    assign Dato_R = rdata_r;
    assign FRW    = frw_r;
    assign Busy   = busy_r;
    assign CS_n   = cs_n_r;
    assign RD_n   = rd_n_r;
    assign WR_n   = wr_n_r;
    assign A_D    = a_d_r;
    assign AD_out = ad_out_r;
    assign AD_oe  = ad_oe_r;

    rtc_bus_ctrl_chk u_chk (
        .CLK   (CLK),
        .RST   (RST),
        .FRW   (FRW),
        .Busy  (Busy),
        .CS_n  (CS_n),
        .RD_n  (RD_n),
        .WR_n  (WR_n),
        .AD_oe (AD_oe)
    );

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// Scoreboard bench for rtc_bus_ctrl: a driver issues requests and queues the
// expected outcome; a monitor watches the bus and checks on every FRW.
module tb_rtc_bus_ctrl;

    localparam int T_SU  = 2;
    localparam int T_PW  = 4;
    localparam int T_H   = 2;
    localparam int T_REC = 1;
    // CS_n is low for LAT cycles; FRW shows LAT edges after the accepting edge
    localparam int LAT   = 2 * (T_SU + T_PW + T_H);

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       Acceso = 1'b0;
    logic       Mod = 1'b0;
    logic [7:0] Dir = 8'h00;
    logic [7:0] Dato_W = 8'h00;
    logic [7:0] Dato_R, AD_out, AD_in;
    logic       FRW, Busy, CS_n, RD_n, WR_n, A_D, AD_oe;

    typedef struct packed {
        logic        wr;
        logic [7:0]  adr;
        logic [7:0]  dat;
        logic [7:0]  rd;
        logic [31:0] frw;
    } item_t;

    item_t      exp_q[$];
    item_t      mon_e;
    logic [7:0] ref_mem [256];
    logic [7:0] rtc_mem [256];
    logic [7:0] rtc_adr;
    logic [7:0] last_rd = 8'h00;
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_err = 0;
    int         last_frw = 0;
    bit         hold_prev = 1'b0;
    int         rst_gen = 0;
    int         seen_gen = 0;

    logic [7:0] cap_adr, cap_dat;
    int         wa_cnt, wd_cnt, rd_cnt, cs_cnt, cs_high;
    bit         adr_bad, dat_bad, oe_bad;

    rtc_bus_ctrl dut (
        .CLK    (CLK),
        .RST    (RST),
        .Acceso (Acceso),
        .Mod    (Mod),
        .Dir    (Dir),
        .Dato_W (Dato_W),
        .Dato_R (Dato_R),
        .FRW    (FRW),
        .Busy   (Busy),
        .CS_n   (CS_n),
        .RD_n   (RD_n),
        .WR_n   (WR_n),
        .A_D    (A_D),
        .AD_out (AD_out),
        .AD_oe  (AD_oe),
        .AD_in  (AD_in)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // RTC chip model: address latched under WR_n with A_D=0, data written under WR_n with A_D=1
    assign AD_in = (!RD_n) ? rtc_mem[rtc_adr] : 8'hA5;
    always @(posedge CLK) begin
        if (!CS_n && !WR_n && !A_D) rtc_adr <= AD_out;
        if (!CS_n && !WR_n && A_D) rtc_mem[rtc_adr] <= AD_out;
    end

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic void clear_caps();
        wa_cnt = 0; wd_cnt = 0; rd_cnt = 0; cs_cnt = 0;
        adr_bad = 1'b0; dat_bad = 1'b0; oe_bad = 1'b0;
        cap_adr = 8'h00; cap_dat = 8'h00;
    endfunction

    // Monitor: accumulate bus observations, check against the queued expectation at each FRW
    always @(negedge CLK) begin
        if (RST === 1'b1 || rst_gen != seen_gen) begin
            seen_gen = rst_gen;
            clear_caps();
            cs_high = 0;
        end else begin
            if (CS_n === 1'b1) begin
                cs_high++;
            end else begin
                if (cs_high > 0) chk("cs_gap", (cs_high >= T_REC), 1);
                cs_high = 0;
                cs_cnt++;
            end
            if (!WR_n && !A_D) begin
                if (wa_cnt > 0 && AD_out !== cap_adr) adr_bad = 1'b1;
                if (AD_oe !== 1'b1) oe_bad = 1'b1;
                cap_adr = AD_out;
                wa_cnt++;
            end
            if (!WR_n && A_D) begin
                if (wd_cnt > 0 && AD_out !== cap_dat) dat_bad = 1'b1;
                if (AD_oe !== 1'b1) oe_bad = 1'b1;
                cap_dat = AD_out;
                wd_cnt++;
            end
            if (!RD_n) begin
                rd_cnt++;
                if (AD_oe !== 1'b0) oe_bad = 1'b1;
            end
            if (!CS_n && A_D && exp_q.size() > 0 && !exp_q[0].wr && AD_oe !== 1'b0) oe_bad = 1'b1;
            if (FRW === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("frw_unexpected", exp_q.size(), 1);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("frw_cycle", cyc, mon_e.frw);
                    chk("addr", {adr_bad, cap_adr}, {1'b0, mon_e.adr});
                    chk("strobes", {8'(wa_cnt), 8'(wd_cnt), 8'(rd_cnt)},
                        {8'(T_PW), mon_e.wr ? 8'(T_PW) : 8'd0, mon_e.wr ? 8'd0 : 8'(T_PW)});
                    if (mon_e.wr) chk("wdata", {dat_bad, cap_dat}, {1'b0, mon_e.dat});
                    chk("dato_r", Dato_R, mon_e.rd);
                    chk("cs_low_len", cs_cnt, LAT);
                    chk("bus_oe", oe_bad, 0);
                    chk("busy_at_frw", Busy, 1);
                end
                clear_caps();
            end
        end
    end

    task automatic push_init(input int r0);
        item_t e;
        e.wr = 1'b1; e.adr = 8'h02; e.rd = last_rd;
        e.dat = 8'h10; e.frw = r0 + LAT + 1;
        exp_q.push_back(e);
        e.dat = 8'h00; e.frw = r0 + 2 * (LAT + 1) + T_REC;
        exp_q.push_back(e);
        ref_mem[8'h02] = 8'h00;
        last_frw = e.frw;
    endtask

    // Assert reset for one edge, check the reset values, then queue the init writes
    task automatic do_reset();
        RST = 1'b1; Acceso = 1'b0;
        exp_q.delete();
        last_rd = 8'h00; hold_prev = 1'b0;
        rst_gen++;
        @(negedge CLK);
        chk("rst_ctrl", {CS_n, RD_n, WR_n, A_D, AD_oe, FRW, Busy}, 7'b1110001);
        chk("rst_ad_out", AD_out, 0);
        chk("rst_dato_r", Dato_R, 0);
        RST = 1'b0;
        push_init(cyc);
    endtask

    // mode 0: quiet, 1: noise on the inputs while busy, 2: hold Acceso and step Dir to nxt at FRW
    task automatic issue(input logic m, input logic [7:0] d, input logic [7:0] w, input int mode,
                         input logic [7:0] nxt);
        item_t e;
        int k;
        int a;
        bit seen;
        k = 0;
        @(negedge CLK);
        while (Busy !== 1'b0 && k < 300) begin
            @(negedge CLK);
            k++;
        end
        if (Busy !== 1'b0) begin
            chk("ready_timeout", Busy, 0);
            return;
        end
        Acceso = 1'b1; Mod = m; Dir = d; Dato_W = w;
        a = cyc + 1;
        if (hold_prev) chk("b2b_accept", a, last_frw + T_REC + 1);
        e.wr = m; e.adr = d; e.dat = w; e.frw = a + LAT;
        if (m) begin
            ref_mem[d] = w;
        end else begin
            last_rd = ref_mem[d];
        end
        e.rd = last_rd;
        exp_q.push_back(e);
        last_frw = e.frw;
        hold_prev = (mode == 2);
        seen = 1'b0;
        k = 0;
        while (!seen && k < 40) begin
            @(negedge CLK);
            k++;
            if (FRW === 1'b1) begin
                seen = 1'b1;
            end else if (mode == 1) begin
                Acceso = 1'($urandom_range(0, 1));
                Mod    = 1'($urandom_range(0, 1));
                Dir    = 8'($urandom);
                Dato_W = 8'($urandom);
            end else if (mode == 0) begin
                Acceso = 1'b0;
            end else begin
                Acceso = 1'b1;
            end
        end
        if (!seen) chk("frw_timeout", seen, 1);
        if (mode == 2) begin
            Dir = nxt;
        end else begin
            Acceso = 1'b0;
        end
    endtask

    task automatic abort_read(input logic [7:0] d);
        int k;
        k = 0;
        @(negedge CLK);
        while (Busy !== 1'b0 && k < 300) begin
            @(negedge CLK);
            k++;
        end
        chk("abort_ready", Busy, 0);
        Acceso = 1'b1; Mod = 1'b0; Dir = d;
        @(negedge CLK);
        Acceso = 1'b0;
        k = 0;
        while (RD_n !== 1'b0 && k < 40) begin
            @(negedge CLK);
            k++;
        end
        chk("abort_rd_strobe", RD_n, 0);
        do_reset();
    endtask

    initial begin
        logic [7:0] cur;
        logic [7:0] nxt;
        int md;
        int k;
        for (int i = 0; i < 256; i++) begin
            rtc_mem[i] = 8'($urandom);
            ref_mem[i] = rtc_mem[i];
        end
        rtc_mem[8'h41] = 8'h59;
        ref_mem[8'h41] = 8'h59;
        clear_caps();
        cs_high = 0;

        do_reset();
        issue(1'b1, 8'h21, 8'h35, 0, 8'h00);
        issue(1'b0, 8'h41, 8'h00, 0, 8'h00);
        issue(1'b1, 8'h23, 8'h5A, 1, 8'h00);
        issue(1'b0, 8'h23, 8'h00, 1, 8'h00);
        issue(1'b1, 8'h21, 8'h77, 2, 8'h22);
        issue(1'b1, 8'h22, 8'h13, 0, 8'h00);
        issue(1'b0, 8'h41, 8'h00, 0, 8'h00);
        abort_read(8'h41);
        issue(1'b0, 8'h02, 8'h00, 0, 8'h00);

        cur = 8'($urandom);
        for (int n = 0; n < 30; n++) begin
            md  = (n == 29) ? 0 : int'($urandom_range(0, 2));
            nxt = 8'($urandom);
            issue(1'($urandom_range(0, 1)), cur, 8'($urandom), md, nxt);
            cur = (md == 2) ? nxt : 8'($urandom);
        end

        k = 0;
        while (exp_q.size() > 0 && k < 100) begin
            @(negedge CLK);
            k++;
        end
        chk("drain", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
